commit_trace_monitor: RTL and testbench

//  Synthesizable retirement monitor for the pipelined cpu. Sits beside the WB/MEM stages.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/trace_fifo.sv | 69 ++++++
 rtl/commit_trace_monitor.sv | 173 +++++++++++++++++
 tb/tb_commit_trace_monitor.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the commit trace monitor.
// Contents:
//   trc_kind_e     trace entry kind encoding (REG, LOAD, STORE, HALT)
//   TRC_MAX_EVENTS most events a single retirement cycle can produce
//   accept_count() how many of this cycle's events fit in the free FIFO slots
// The trace entry struct lives in the top module because its field widths
// follow the top's DATA_W/CNT_W parameters.
package cpu_pkg;

    typedef enum logic [1:0] {
        TRC_REG   = 2'd0,
        TRC_LOAD  = 2'd1,
        TRC_STORE = 2'd2,
        TRC_HALT  = 2'd3
    } trc_kind_e;

    localparam int TRC_MAX_EVENTS = 3;

    // Events are packed in enqueue order, so keeping the first 'free' of them
    // drops the latest ones first.
    function automatic logic [1:0] accept_count(input logic [1:0] n_events,
                                                input int unsigned free_slots);
        if (free_slots < int'(n_events)) begin
            return free_slots[1:0];
        end
        return n_events;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular trace buffer with up to three writes and one read per cycle.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (empties the buffer)
//   wr_cnt       number of entries to write this cycle (0..3), taken from
//                wr_data[0], wr_data[1], wr_data[2] in that order
//   wr_data      candidate entries
//   rd_en        consumer accepts the head; ignored while empty
//   rd_data      head entry (valid while valid=1)
//   valid        buffer not empty
//   count        occupancy, 0..DEPTH
// The writer must never offer more entries than DEPTH - count.
module trace_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               wr_cnt,
    input  logic [2:0][W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          pop;

    always_comb begin
        pop = rd_en && (count_q != '0);
        mem_d = mem_q;
        for (int k = 0; k < 3; k++) begin
            if (k < int'(wr_cnt)) begin
                mem_d[wr_ptr_q + AW'(k)] = wr_data[k];
            end
        end
        // Pointers wrap naturally because DEPTH is a power of two.
        wr_ptr_d = wr_ptr_q + AW'(wr_cnt);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + {{(AW-1){1'b0}}, wr_cnt} - {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign valid   = (count_q != '0);
    assign count   = count_q;

endmodule

// File: rtl/commit_trace_monitor.sv
// Retirement monitor: turns WB/MEM retirement activity into a trace stream.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   wb_reg_write/rd/data       register file write this cycle
//   mem_read/write/addr/wdata/rdata  completed memory access this cycle
//   hlt                        halt retiring this cycle
//   trc_valid/ready            head-of-FIFO handshake
//   trc_kind/addr/data/cycle   head entry payload
//   cycle_count/inst_count/drop_count  saturating statistics
//   halted, wdog_timeout       sticky stop flags (capture freezes when set)
module commit_trace_monitor
    import cpu_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_AW     = 4,
    parameter int DEPTH      = 16,
    parameter int CNT_W      = 32,
    parameter int WDOG_LIMIT = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_reg_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              hlt,
    output logic              trc_valid,
    input  logic              trc_ready,
    output logic [1:0]        trc_kind,
    output logic [DATA_W-1:0] trc_addr,
    output logic [DATA_W-1:0] trc_data,
    output logic [CNT_W-1:0]  trc_cycle,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  inst_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic              halted,
    output logic              wdog_timeout
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        trc_kind_e          kind;
        logic [DATA_W-1:0]  addr;
        logic [DATA_W-1:0]  data;
        logic [CNT_W-1:0]   cycle;
    } trc_entry_t;

    localparam int ENTRY_W = $bits(trc_entry_t);
    localparam bit WDOG_EN = (WDOG_LIMIT != 0);
    // Only meaningful when WDOG_EN; the comparison below is gated by it.
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_LIMIT - 1);

    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0] inst_count_q, inst_count_d;
    logic [CNT_W-1:0] drop_count_q, drop_count_d;
    logic             halted_q, halted_d;
    logic             wdog_timeout_q, wdog_timeout_d;

    logic                       active;
    trc_entry_t [2:0]           ev;
    logic [1:0]                 ev_cnt;
    logic [1:0]                 wr_cnt;
    logic [1:0]                 drop_n;
    logic [AW:0]                fifo_count;
    logic [AW:0]                free_slots;
    logic [ENTRY_W-1:0]         head_bits;
    trc_entry_t                 head;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    // Pack this cycle's events densely in REG, LOAD/STORE, HALT order.
    always_comb begin
        active = !halted_q && !wdog_timeout_q;
        ev     = '0;
        ev_cnt = 2'd0;
        if (active && wb_reg_write) begin
            ev[ev_cnt] = '{kind: TRC_REG, addr: DATA_W'(wb_reg_rd),
                           data: wb_data, cycle: cycle_count_q};
            ev_cnt = ev_cnt + 2'd1;
        end
        // A simultaneous read and write is reported as the store only.
        if (active && mem_write) begin
            ev[ev_cnt] = '{kind: TRC_STORE, addr: mem_addr,
                           data: mem_wdata, cycle: cycle_count_q};
            ev_cnt = ev_cnt + 2'd1;
        end else if (active && mem_read) begin
            ev[ev_cnt] = '{kind: TRC_LOAD, addr: mem_addr,
                           data: mem_rdata, cycle: cycle_count_q};
            ev_cnt = ev_cnt + 2'd1;
        end
        if (active && hlt) begin
            ev[ev_cnt] = '{kind: TRC_HALT, addr: '0, data: '0, cycle: cycle_count_q};
            ev_cnt = ev_cnt + 2'd1;
        end

        // Free space excludes any same-cycle pop: no credit for the head leaving.
        free_slots = (AW+1)'(DEPTH) - fifo_count;
        wr_cnt     = accept_count(ev_cnt, int'(free_slots));
        drop_n     = ev_cnt - wr_cnt;
    end

    always_comb begin
        cycle_count_d  = cycle_count_q;
        inst_count_d   = inst_count_q;
        drop_count_d   = sat_add(drop_count_q, drop_n);
        halted_d       = halted_q;
        wdog_timeout_d = wdog_timeout_q;
        if (active) begin
            cycle_count_d = sat_add(cycle_count_q, 2'd1);
            if (hlt || wb_reg_write || mem_write) begin
                inst_count_d = sat_add(inst_count_q, 2'd1);
            end
            // Halt on the same edge takes priority over the watchdog.
            if (hlt) begin
                halted_d = 1'b1;
            end else if (WDOG_EN && (cycle_count_q == WDOG_LAST)) begin
                wdog_timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_count_q  <= '0;
            inst_count_q   <= '0;
            drop_count_q   <= '0;
            halted_q       <= 1'b0;
            wdog_timeout_q <= 1'b0;
        end else begin
            cycle_count_q  <= cycle_count_d;
            inst_count_q   <= inst_count_d;
            drop_count_q   <= drop_count_d;
            halted_q       <= halted_d;
            wdog_timeout_q <= wdog_timeout_d;
        end
    end

    trace_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_cnt  (wr_cnt),
        .wr_data (ev),
        .rd_en   (trc_ready),
        .rd_data (head_bits),
        .valid   (trc_valid),
        .count   (fifo_count)
    );

    assign head         = trc_entry_t'(head_bits);
    assign trc_kind     = head.kind;
    assign trc_addr     = head.addr;
    assign trc_data     = head.data;
    assign trc_cycle    = head.cycle;
    assign cycle_count  = cycle_count_q;
    assign inst_count   = inst_count_q;
    assign drop_count   = drop_count_q;
    assign halted       = halted_q;
    assign wdog_timeout = wdog_timeout_q;

endmodule

// File: tb/tb_commit_trace_monitor.sv
// Directed bench for commit_trace_monitor (DEPTH=4, WDOG_LIMIT=10).
// A queue-based reference model is advanced once per clock by the stimulus;
// a negedge process compares every output against it, and each scenario
// also pins a few hand-computed literal values.
module tb_commit_trace_monitor;

    localparam int DEPTH = 4;
    localparam int WDOG  = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_reg_write;
    logic [3:0]  wb_reg_rd;
    logic [15:0] wb_data;
    logic        mem_read, mem_write;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        hlt;
    logic        trc_valid, trc_ready;
    logic [1:0]  trc_kind;
    logic [15:0] trc_addr, trc_data;
    logic [31:0] trc_cycle, cycle_count, inst_count, drop_count;
    logic        halted, wdog_timeout;

    commit_trace_monitor #(
        .DATA_W(16), .REG_AW(4), .DEPTH(DEPTH), .CNT_W(32), .WDOG_LIMIT(WDOG)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_reg_write(wb_reg_write), .wb_reg_rd(wb_reg_rd), .wb_data(wb_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .hlt(hlt),
        .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_kind(trc_kind),
        .trc_addr(trc_addr), .trc_data(trc_data), .trc_cycle(trc_cycle),
        .cycle_count(cycle_count), .inst_count(inst_count), .drop_count(drop_count),
        .halted(halted), .wdog_timeout(wdog_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [15:0] data;
        logic [31:0] cyc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_cycle, m_inst, m_drop;
    bit          m_halted, m_wdog;
    bit          chk_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t mk(input int k, input logic [15:0] a,
                                input logic [15:0] d, input logic [31:0] c);
        ent_t e;
        e.kind = k; e.addr = a; e.data = d; e.cyc = c;
        return e;
    endfunction

    function automatic logic [31:0] inc_sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Reference behaviour for one clock edge using the currently driven inputs.
    task automatic model_step();
        ent_t ev[$];
        int   free;
        bit   act;
        if (!rst_n) begin
            mq.delete();
            m_cycle = 0; m_inst = 0; m_drop = 0; m_halted = 0; m_wdog = 0;
            return;
        end
        act  = !m_halted && !m_wdog;
        free = DEPTH - mq.size();
        if (act) begin
            if (wb_reg_write) ev.push_back(mk(0, {12'd0, wb_reg_rd}, wb_data, m_cycle));
            if (mem_write)     ev.push_back(mk(2, mem_addr, mem_wdata, m_cycle));
            else if (mem_read) ev.push_back(mk(1, mem_addr, mem_rdata, m_cycle));
            if (hlt)           ev.push_back(mk(3, 16'd0, 16'd0, m_cycle));
        end
        if (mq.size() > 0 && trc_ready) void'(mq.pop_front());
        foreach (ev[i]) begin
            if (i < free) mq.push_back(ev[i]);
            else m_drop = inc_sat(m_drop);
        end
        if (act) begin
            if (hlt || wb_reg_write || mem_write) m_inst = inc_sat(m_inst);
            if (hlt) m_halted = 1;
            else if (m_cycle == 32'(WDOG - 1)) m_wdog = 1;
            m_cycle = inc_sat(m_cycle);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("trc_valid", trc_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("trc_kind", trc_kind, mq[0].kind);
                chk("trc_addr", trc_addr, mq[0].addr);
                chk("trc_data", trc_data, mq[0].data);
                chk("trc_cycle", trc_cycle, mq[0].cyc);
            end
            chk("cycle_count", cycle_count, m_cycle);
            chk("inst_count", inst_count, m_inst);
            chk("drop_count", drop_count, m_drop);
            chk("halted", halted, m_halted);
            chk("wdog_timeout", wdog_timeout, m_wdog);
        end
    end

    task automatic idle();
        wb_reg_write = 0; wb_reg_rd = 0; wb_data = 0;
        mem_read = 0; mem_write = 0; mem_addr = 0; mem_wdata = 0; mem_rdata = 0;
        hlt = 0;
    endtask

    // Inputs are already set; advance model and DUT by one edge.
    task automatic step();
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        step();
        rst_n = 1;
    endtask

    task automatic reg_wr(input logic [3:0] rd, input logic [15:0] d);
        idle();
        wb_reg_write = 1; wb_reg_rd = rd; wb_data = d;
        step();
        idle();
    endtask

    int          exp_kind[4];
    logic [15:0] exp_data[4];

    initial begin
        idle();
        rst_n = 0;
        trc_ready = 0;
        @(negedge clk);
        #1;
        chk_en = 1;

        // 1: single register write at cycle 5
        do_reset();
        chk("rst_valid", trc_valid, 1'b0);
        chk("rst_cycle", cycle_count, 32'd0);
        steps(5);
        reg_wr(4'd3, 16'h1234);
        chk("t1_kind", trc_kind, 2'd0);
        chk("t1_addr", trc_addr, 16'h0003);
        chk("t1_data", trc_data, 16'h1234);
        chk("t1_cycle", trc_cycle, 32'd5);
        chk("t1_inst", inst_count, 32'd1);

        // 2: REG + STORE (with read also asserted) + HALT on one cycle
        do_reset();
        steps(2);
        wb_reg_write = 1; wb_reg_rd = 4'd1; wb_data = 16'hBEEF;
        mem_write = 1; mem_read = 1; mem_addr = 16'h0040; mem_wdata = 16'h00AA;
        mem_rdata = 16'h0077; hlt = 1;
        step();
        idle();
        chk("t2_halted", halted, 1'b1);
        chk("t2_inst", inst_count, 32'd1);
        wb_reg_write = 1; wb_reg_rd = 4'd9; wb_data = 16'h0999;
        steps(3);
        idle();
        chk("t2_frozen_cycle", cycle_count, 32'd3);
        chk("t2_frozen_inst", inst_count, 32'd1);
        exp_kind = '{0, 2, 3, 0};
        exp_data = '{16'hBEEF, 16'h00AA, 16'h0000, 16'h0000};
        trc_ready = 1;
        for (int k = 0; k < 3; k++) begin
            chk("t2_drain_kind", trc_kind, exp_kind[k]);
            chk("t2_drain_data", trc_data, exp_data[k]);
            step();
        end
        chk("t2_empty", trc_valid, 1'b0);
        trc_ready = 0;

        // 3: overflow drops latest events, then ordered drain
        do_reset();
        reg_wr(4'd1, 16'h0011);
        reg_wr(4'd2, 16'h0022);
        reg_wr(4'd3, 16'h0033);
        mem_read = 1; mem_addr = 16'h0010; mem_rdata = 16'h0055;
        step();
        wb_reg_write = 1; wb_reg_rd = 4'd4; wb_data = 16'h0044;
        mem_read = 1; mem_addr = 16'h0020; mem_rdata = 16'h0066;
        step();
        idle();
        chk("t3_drop", drop_count, 32'd2);
        chk("t3_inst", inst_count, 32'd4);
        exp_kind = '{0, 0, 0, 1};
        exp_data = '{16'h0011, 16'h0022, 16'h0033, 16'h0055};
        trc_ready = 1;
        for (int k = 0; k < 4; k++) begin
            chk("t3_drain_kind", trc_kind, exp_kind[k]);
            chk("t3_drain_data", trc_data, exp_data[k]);
            step();
        end
        chk("t3_empty", trc_valid, 1'b0);
        trc_ready = 0;

        // 4: full FIFO, pop and REG on same cycle -> REG dropped
        do_reset();
        for (int k = 0; k < 4; k++) reg_wr(4'(k), 16'hA0 + 16'(k));
        trc_ready = 1;
        reg_wr(4'd7, 16'h00F7);
        trc_ready = 0;
        chk("t4_drop", drop_count, 32'd1);
        chk("t4_head", trc_data, 16'h00A1);

        // 5: watchdog expiry after 10 active cycles
        do_reset();
        steps(9);
        chk("t5_pre_wdog", wdog_timeout, 1'b0);
        reg_wr(4'd2, 16'h005A);
        chk("t5_wdog", wdog_timeout, 1'b1);
        chk("t5_cycle", cycle_count, 32'd10);
        chk("t5_stamp", trc_cycle, 32'd9);
        reg_wr(4'd3, 16'h005B);
        reg_wr(4'd4, 16'h005C);
        chk("t5_frozen_inst", inst_count, 32'd1);

        // 5b: halt on the watchdog edge wins
        do_reset();
        steps(9);
        hlt = 1;
        step();
        idle();
        steps(2);
        chk("t5b_halted", halted, 1'b1);
        chk("t5b_wdog", wdog_timeout, 1'b0);

        // 6: reset while entries are queued
        do_reset();
        reg_wr(4'd1, 16'h0001);
        reg_wr(4'd2, 16'h0002);
        reg_wr(4'd3, 16'h0003);
        rst_n = 0;
        step();
        rst_n = 1;
        chk("t6_valid", trc_valid, 1'b0);
        chk("t6_inst", inst_count, 32'd0);
        chk("t6_cycle", cycle_count, 32'd0);
        reg_wr(4'd5, 16'h0077);
        chk("t6_resume_valid", trc_valid, 1'b1);
        chk("t6_resume_stamp", trc_cycle, 32'd0);

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
